// File: rtl/morse_rx.sv
// Morse receiver: synchronises a keyed line, times marks and spaces in Morse
// units, and reports decoded letters, over-long letters and word gaps.
module morse_rx #(
  parameter int UNIT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key,
  output logic [4:0] sym,
  output logic [2:0] len,
  output logic       valid,
  output logic       err,
  output logic       word
);

  localparam int             MAX_ELEM = 5;
  localparam int             CW       = (UNIT_CYCLES > 2) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [CW-1:0]  CYC_LAST = CW'(UNIT_CYCLES - 1);
  localparam logic [2:0]     MAX_LEN  = 3'(MAX_ELEM);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    SPACE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic          key_meta;
  logic          key_s;
  logic          key_prev;
  logic          key_edge;

  logic [CW-1:0] cyc;
  logic [2:0]    units;

  logic [4:0]    shreg;
  logic [2:0]    count;
  logic          ovf;
  logic          lsw;

  logic          elem_valid;
  logic          elem;
  logic          letter_end;
  logic          word_end;

  assign key_edge = key_s ^ key_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      key_meta <= 1'b0;
      key_s    <= 1'b0;
      key_prev <= 1'b0;
    end else begin
      key_meta <= key;
      key_s    <= key_meta;
      key_prev <= key_s;
    end
  end

  // The edge cycle counts as the first cycle of the new level, so a level of
  // L cycles reads floor(L/UNIT_CYCLES) units in the cycle that ends it.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc   <= '0;
      units <= 3'd0;
    end else if (key_edge) begin
      cyc   <= CW'(1);
      units <= 3'd0;
    end else if (state == IDLE) begin
      cyc   <= '0;
      units <= 3'd0;
    end else if (cyc == CYC_LAST) begin
      cyc   <= '0;
      units <= (units == 3'd7) ? 3'd7 : units + 3'd1;
    end else begin
      cyc   <= cyc + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (key_s) begin
          state_nxt = MARK;
        end
      end
      MARK: begin
        if (!key_s) begin
          if (units == 3'd0 && count == 3'd0) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = SPACE;
          end
        end
      end
      SPACE: begin
        // A rise coinciding with a unit threshold still starts a new mark.
        if (word_end) begin
          state_nxt = key_s ? MARK : IDLE;
        end else if (key_s) begin
          state_nxt = MARK;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    elem_valid = 1'b0;
    elem       = 1'b0;
    letter_end = 1'b0;
    word_end   = 1'b0;
    if (state == MARK && !key_s && units != 3'd0) begin
      elem_valid = 1'b1;
      elem       = (units >= 3'd3);
    end
    if (state == SPACE && units == 3'd3 && count != 3'd0) begin
      letter_end = 1'b1;
    end
    if (state == SPACE && units == 3'd7) begin
      word_end = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= 5'd0;
      count <= 3'd0;
      ovf   <= 1'b0;
      lsw   <= 1'b0;
      sym   <= 5'd0;
      len   <= 3'd0;
      valid <= 1'b0;
      err   <= 1'b0;
      word  <= 1'b0;
    end else begin
      valid <= 1'b0;
      err   <= 1'b0;
      word  <= 1'b0;
      if (elem_valid) begin
        if (count == MAX_LEN) begin
          ovf <= 1'b1;
        end else begin
          shreg <= {shreg[3:0], elem};
          count <= count + 3'd1;
        end
      end
      // An over-long letter is reported but never replaces the last good one.
      if (letter_end) begin
        if (ovf) begin
          err <= 1'b1;
        end else begin
          valid <= 1'b1;
          sym   <= shreg;
          len   <= count;
        end
        shreg <= 5'd0;
        count <= 3'd0;
        ovf   <= 1'b0;
        lsw   <= 1'b1;
      end
      if (word_end) begin
        word <= lsw;
        lsw  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/morse_rx.md
# morse_rx

Receive-side Morse decoder: the counterpart of the Morse transmitter. Samples a single keyed line, measures mark and space durations in Morse time units, and classifies each mark as dot or dash. Assembles up to 5 elements per letter and presents each completed letter as a pattern/length pair with a one-cycle strobe. Also flags word gaps and over-long letters. Sits between the external key/tone-detect input and the character-lookup logic.

## Interface
- UNIT_CYCLES, default 4: clock cycles per Morse time unit (must be ≥2).
- MAX_ELEM, fixed at 5: maximum elements per letter. Not user-changeable; it sets the SYM width.
- CLK  input  1  system clock; all logic is on its rising edge.
- RST  input  1  synchronous, active-high reset.
- KEY  input  1  asynchronous keyed line; 1 = mark (tone), 0 = space.
- SYM  output  5  last decoded letter. Element i is at bit LEN-1-i, with the first element in the highest used bit. 1 = dash, 0 = dot. Unused upper bits are 0.
- LEN  output  3  number of elements in SYM (1..5).
- VALID  output  1  one-cycle strobe when a new SYM/LEN is presented.
- ERR  output  1  one-cycle strobe when a letter ends with more than 5 elements.
- WORD  output  1  one-cycle strobe when a word gap is detected.

## Operation
- **Input sync:** KEY passes through two flops to give KEY_S. All decoding uses KEY_S only.
- **Edge-aligned unit timer:**
  - A cycle counter runs 0..UNIT_CYCLES-1 and wraps.
  - Each wrap increments the unit count, which saturates at 7.
  - Both counters clear on every KEY_S transition.
  - For a level lasting L cycles, units = min(floor(L/UNIT_CYCLES), 7).
- **State IDLE:**
  - Letter buffer is empty and the counters are held at 0.
  - KEY_S = 1 → MARK.
- **State MARK:** the cycle KEY_S = 0 ends the mark. Classify the completed units:
  - 0 units → glitch, discarded. Go to SPACE if the buffer is non-empty, else IDLE.
  - 1–2 units → dot. Shift in 0.
  - ≥3 units → dash. Shift in 1.
  - Shifting means buf = {buf[3:0], elem} and count++.
  - A 6th or later element sets an overflow flag. buf and count then stop changing.
  - After any valid element → SPACE.
- **State SPACE:**
  - KEY_S = 1 before 3 units have elapsed → intra-letter gap → MARK. The letter continues.
  - Unit count reaching 3 → letter end:
    - Without overflow: SYM ← buf, LEN ← count, VALID pulses.
    - With overflow: ERR pulses instead. SYM and LEN are unchanged and VALID stays 0.
    - In both cases the buffer and overflow flag clear, and a "letter-since-word" flag is set.
  - After letter end, KEY_S = 1 → MARK and a new letter starts.
  - Unit count reaching 7 → WORD pulses if letter-since-word is set. The flag clears and the state goes to IDLE.
- **Output holding:** SYM and LEN hold their value between VALID strobes.
- **Strobe exclusivity:** VALID, ERR and WORD are never high in the same cycle.

## Timing
- **Reset values:** SYM = 0, LEN = 0, VALID = ERR = WORD = 0. Sync flops = 0, state = IDLE, all counters and flags = 0.
- **Reset priority:** RST overrides every event in the same cycle. A reset mid-letter discards the partial letter with no strobe.
- **Input latency:** 2 cycles from a KEY edge to KEY_S.
- **VALID/ERR timing:** call e0 the rising edge that first samples KEY = 0 after the final mark. VALID (or ERR) is high in the cycle following edge e0 + 2 + 3·UNIT_CYCLES.
- **WORD timing:** high in the cycle following edge e0 + 2 + 7·UNIT_CYCLES, provided KEY stays 0.
- **Simultaneous events:** a KEY_S rise in the same cycle that the unit count reaches 3 counts as the letter end first. The strobe fires, then the state goes to MARK with a new letter.
- **Mark saturation:** marks longer than 7 units still decode as a dash. There is no timeout on an indefinitely held mark.
- **Throughput:** one letter per letter gap; no backpressure. A downstream consumer must capture SYM/LEN on VALID.

## Test plan
All scenarios use UNIT_CYCLES = 4.
- **'A':** mark 4, space 4, mark 12 cycles, then KEY = 0 for 40 cycles → one VALID with SYM = 5'b00001, LEN = 2. Then one WORD exactly 4·4 cycles after VALID.
- **'N' then 'E':** dash, 1-unit gap, dot, 3-unit gap, dot, 3-unit gap → VALID with SYM = 5'b00010, LEN = 2. Then VALID with SYM = 0, LEN = 1. No WORD.
- **Glitch:** 2-cycle KEY pulse in IDLE → no strobes, state returns to IDLE. A 2-cycle pulse inside the gap of an 'A' → still decodes SYM = 1, LEN = 2.
- **Overflow:** six dots at 1-unit spacing, then 3-unit space → ERR for one cycle, no VALID, SYM/LEN keep their previous value. A following 'E' → VALID with LEN = 1.
- **Reset mid-letter:** two dots, then assert RST for 1 cycle, then a 10-unit space → no VALID/ERR/WORD, and all outputs read 0.
- **Latency check:** a single dot, then measure edges from the first sampled KEY = 0 to VALID → 2 + 12 edges exactly.
